// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM encoding, instruction fields.
package alu_sequencer_pkg;

  // External ALU opcodes
  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpAnd   = 3'b010;
  localparam logic [2:0] OpOr    = 3'b011;
  localparam logic [2:0] OpXor   = 3'b100;
  localparam logic [2:0] OpNot   = 3'b101;
  localparam logic [2:0] OpPassB = 3'b110;
  localparam logic [2:0] OpInc   = 3'b111;

  // Instruction word layout
  localparam int unsigned InstrW    = 8;
  localparam int unsigned OpMsb     = 7;
  localparam int unsigned OpLsb     = 5;
  localparam int unsigned RdMsb     = 4;
  localparam int unsigned RdLsb     = 3;
  localparam int unsigned RsMsb     = 2;
  localparam int unsigned RsLsb     = 1;
  localparam int unsigned UseImmBit = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StExec = 2'd2,
    StWb   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile4x8.sv
// 4-entry register file: one synchronous write port, two read ports and a debug read port.
module regfile4x8 #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_a_i,
  output logic [Width-1:0]         rdata_a_o,
  input  logic [$clog2(Depth)-1:0] raddr_b_i,
  output logic [Width-1:0]         rdata_b_o,
  input  logic [$clog2(Depth)-1:0] dbg_addr_i,
  output logic [Width-1:0]         dbg_data_o
);

  logic [Width-1:0] regs_q [Depth];

  // Storage with asynchronous clear; writes land at the end of the write cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads always return the pre-write value in the write cycle
  always_comb begin
    rdata_a_o  = regs_q[raddr_a_i];
    rdata_b_o  = regs_q[raddr_b_i];
    dbg_data_o = regs_q[dbg_addr_i];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase sequencer (accept, read, execute, write back) driving an external ALU.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [InstrW-1:0] instr,
  input  logic [DATA_W-1:0] imm_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              neg_flag,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e              state_q;
  logic [InstrW-1:0]   instr_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   alu_a_q, alu_b_q;
  logic [2:0]          alu_op_q;
  logic                done_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                zero_q, neg_q;

  logic [1:0]          rd, rs;
  logic                use_imm;
  logic [DATA_W-1:0]   rd_data, rs_data;

  // Decode the latched instruction so input changes while busy are invisible
  always_comb begin
    rd      = instr_q[RdMsb:RdLsb];
    rs      = instr_q[RsMsb:RsLsb];
    use_imm = instr_q[UseImmBit];
  end

  regfile4x8 #(
    .Width (DATA_W),
    .Depth (NREGS)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (state_q == StWb),
    .waddr_i    (rd),
    .wdata_i    (wb_data_q),
    .raddr_a_i  (rd),
    .rdata_a_o  (rd_data),
    .raddr_b_i  (rs),
    .rdata_b_o  (rs_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Sequencer FSM with all outputs registered; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      imm_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      done_q    <= 1'b0;
      wb_data_q <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            instr_q <= instr;
            imm_q   <= imm_data;
            state_q <= StRead;
          end
        end
        StRead: begin
          alu_a_q  <= rd_data;
          alu_b_q  <= use_imm ? imm_q : rs_data;
          alu_op_q <= instr_q[OpMsb:OpLsb];
          state_q  <= StExec;
        end
        StExec: begin
          // Result and flags become visible together with done in the WB cycle
          wb_data_q <= alu_result;
          zero_q    <= (alu_result == '0);
          neg_q     <= alu_result[DATA_W-1];
          done_q    <= 1'b1;
          state_q   <= StWb;
        end
        StWb: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Drive ports from the registered state
  always_comb begin
    instr_ready = (state_q == StIdle);
    alu_a       = alu_a_q;
    alu_b       = alu_b_q;
    alu_op      = alu_op_q;
    done        = done_q;
    wb_data     = wb_data_q;
    zero_flag   = zero_q;
    neg_flag    = neg_q;
  end

endmodule
